// File: rtl/avg_batch_feeder_if.sv
// ============================================================================
// Module   : avg_batch_feeder_if
// Brief    : Sample stream, HLSM handshake and result stream of the batch feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface avg_batch_feeder_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic signed [7:0] num_cfg;
  logic              hlsm_start;
  logic              hlsm_done;
  logic signed [7:0] hlsm_avg;
  logic signed [7:0] a, b, c, d, e, f, g, h;
  logic signed [7:0] num;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_avg;
  logic              err_div0;
  logic              err_timeout;

  // Environment side: sample producer, HLSM and result consumer.
  modport master (
    output in_valid, in_data, num_cfg, hlsm_done, hlsm_avg, out_ready,
    input  in_ready, hlsm_start, a, b, c, d, e, f, g, h, num,
    input  out_valid, out_avg, err_div0, err_timeout
  );

  modport slave (
    input  in_valid, in_data, num_cfg, hlsm_done, hlsm_avg, out_ready,
    output in_ready, hlsm_start, a, b, c, d, e, f, g, h, num,
    output out_valid, out_avg, err_div0, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/avg_batch_feeder.sv
// ============================================================================
// Module   : avg_batch_feeder
// Brief    : Collects 8 samples, launches the HLSM averager, buffers its result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module avg_batch_feeder #(
  parameter int TIMEOUT = 32
) (
  input logic               Clk,
  input logic               Rst,
  avg_batch_feeder_if.slave bus
);

  localparam int c_TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    OUT       = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic        [2:0]  r_cnt;
  logic [c_TMO_W-1:0] r_tmo;
  logic [c_TMO_W-1:0] w_tmo_inc;
  logic signed [7:0]  r_slot [8];
  logic signed [7:0]  r_num;
  logic signed [7:0]  r_out_avg;
  logic               r_err_div0;
  logic               r_err_timeout;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_last;
  logic               w_capture;
  logic               w_timeout;

  assign w_in_ready = (r_state == FILL) && !Rst;
  assign w_tmo_inc  = r_tmo + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      FILL: begin
        if (bus.in_valid && w_in_ready) begin
          w_accept = 1'b1;
          if (r_cnt == 3'd7) begin
            w_last      = 1'b1;
            w_state_nxt = LAUNCH;
          end
        end
      end
      LAUNCH:
        w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (bus.hlsm_done) begin
          w_capture   = 1'b1;
          w_state_nxt = OUT;
        end else if (w_tmo_inc == c_TMO_W'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = FILL;
        end
      end
      OUT: begin
        if (bus.out_ready) w_state_nxt = FILL;
      end
      default:
        w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= FILL;
      r_cnt         <= 3'd0;
      r_tmo         <= '0;
      r_num         <= 8'sd0;
      r_out_avg     <= 8'sd0;
      r_err_div0    <= 1'b0;
      r_err_timeout <= 1'b0;
      for (int i = 0; i < 8; i++) r_slot[i] <= 8'sd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_slot[r_cnt] <= bus.in_data;
        r_cnt         <= w_last ? 3'd0 : r_cnt + 3'd1;
      end
      // A zero divisor would hang or corrupt the HLSM; substitute the batch size.
      if (w_last) begin
        if (bus.num_cfg == 8'sd0) begin
          r_num      <= 8'sd8;
          r_err_div0 <= 1'b1;
        end else begin
          r_num <= bus.num_cfg;
        end
      end
      if (r_state == LAUNCH)         r_tmo <= '0;
      else if (r_state == WAIT_DONE) r_tmo <= w_tmo_inc;
      if (w_capture) r_out_avg     <= bus.hlsm_avg;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.hlsm_start  = (r_state == LAUNCH);
  assign bus.out_valid   = (r_state == OUT);
  assign bus.out_avg     = r_out_avg;
  assign bus.num         = r_num;
  assign bus.err_div0    = r_err_div0;
  assign bus.err_timeout = r_err_timeout;
  assign bus.a = r_slot[0];
  assign bus.b = r_slot[1];
  assign bus.c = r_slot[2];
  assign bus.d = r_slot[3];
  assign bus.e = r_slot[4];
  assign bus.f = r_slot[5];
  assign bus.g = r_slot[6];
  assign bus.h = r_slot[7];

endmodule

`default_nettype wire

// File: tb/tb_avg_batch_feeder.sv
// ============================================================================
// Module   : tb_avg_batch_feeder
// Brief    : Randomized bench for avg_batch_feeder with an HLSM stub and batch model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_avg_batch_feeder;
  localparam int TMO = 32;

  logic Clk = 1'b0;
  logic Rst;
  avg_batch_feeder_if bus();

  avg_batch_feeder #(.TIMEOUT(TMO)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  int                n_tests  = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  int                stub_cnt = 0;
  bit                stub_mute = 1'b0;
  bit                exp_div0, exp_tmo;
  logic signed [7:0] last_avg;
  logic signed [7:0] bs [8];

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic signed [7:0] quot(input int sum, input logic signed [7:0] dv);
    int q;
    if (dv == 8'sd0) return 8'sd0;
    q = sum / int'(dv);
    return q[7:0];
  endfunction

  function automatic logic [63:0] dut_slots();
    return {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h};
  endfunction

  // One clock; afterwards the HLSM stub raises Done 12 cycles after seeing Start.
  task automatic tick();
    int s;
    @(posedge Clk);
    #1;
    cyc++;
    bus.hlsm_done = 1'b0;
    bus.hlsm_avg  = 8'($urandom);
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0 && !stub_mute) begin
        s = int'(bus.a) + int'(bus.b) + int'(bus.c) + int'(bus.d)
          + int'(bus.e) + int'(bus.f) + int'(bus.g) + int'(bus.h);
        bus.hlsm_done = 1'b1;
        bus.hlsm_avg  = quot(s, bus.num);
      end
    end
    if (bus.hlsm_start) stub_cnt = 12;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_slots"}, dut_slots(), 0);
    check({tag, "_num"}, bus.num, 0);
    check({tag, "_start"}, bus.hlsm_start, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_avg"}, bus.out_avg, 0);
    check({tag, "_div0"}, bus.err_div0, 0);
    check({tag, "_tmo"}, bus.err_timeout, 0);
  endtask

  task automatic run_batch(input logic signed [7:0] ncfg, input int hold, input bit gaps,
                           input bit tmo, input bit rst_mid, output int first_acc);
    int                k, e, guard, bad, sum, limit;
    logic signed [7:0] en, eavg;
    logic [63:0]       slots;
    k = 0; e = 0; guard = 0; bad = 0; sum = 0; first_acc = -1;
    stub_mute     = tmo;
    bus.out_ready = 1'b1;
    while (k < 8 && guard < 200) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data  = bs[k];
      bus.num_cfg  = (k == 7) ? ncfg : 8'($urandom);
      if (bus.in_valid && bus.in_ready) begin
        if (k == 0) first_acc = cyc;
        e = cyc;
        k++;
      end
      tick();
      guard++;
    end
    if (k < 8) begin
      check("fill_stall", k, 8);
      return;
    end
    for (int i = 0; i < 8; i++) sum += int'(bs[i]);
    en    = (ncfg == 8'sd0) ? 8'sd8 : ncfg;
    eavg  = quot(sum, en);
    slots = {bs[0], bs[1], bs[2], bs[3], bs[4], bs[5], bs[6], bs[7]};
    if (ncfg == 8'sd0) exp_div0 = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);

    check("hlsm_start", bus.hlsm_start, 1);
    check("slots", dut_slots(), slots);
    check("num", bus.num, en);
    check("in_ready_launch", bus.in_ready, 0);
    check("err_div0", bus.err_div0, exp_div0);
    check("err_timeout", bus.err_timeout, exp_tmo);

    if (rst_mid) begin
      repeat (4) tick();
      Rst = 1'b1;
      #1;
      check("in_ready_in_rst", bus.in_ready, 0);
      tick();
      Rst = 1'b0;
      check_reset("mid_rst");
      #1;
      check("in_ready_post_rst", bus.in_ready, 1);
      exp_div0 = 1'b0; exp_tmo = 1'b0; last_avg = 8'sd0;
      return;
    end

    tick();
    check("start_pulse", bus.hlsm_start, 0);
    limit = e + (tmo ? 2 + TMO : 14);
    while (cyc < limit) begin
      if (bus.out_valid || bus.in_ready || bus.hlsm_start || bus.err_timeout != exp_tmo
          || dut_slots() != slots || bus.num != en) bad++;
      bus.in_data = 8'($urandom);
      tick();
    end
    check("wait_window", bad, 0);

    if (tmo) begin
      check("tmo_in_ready", bus.in_ready, 1);
      check("tmo_flag", bus.err_timeout, 1);
      check("tmo_no_valid", bus.out_valid, 0);
      exp_tmo       = 1'b1;
      bus.in_valid  = 1'b0;
      bus.hlsm_done = 1'b1;
      bus.hlsm_avg  = 8'sd77;
      tick();
      check("late_done_valid", bus.out_valid, 0);
      check("late_done_ready", bus.in_ready, 1);
      check("late_done_avg", bus.out_avg, last_avg);
      return;
    end

    check("out_valid", bus.out_valid, 1);
    check("out_avg", bus.out_avg, eavg);
    check("in_ready_out", bus.in_ready, 0);
    last_avg = eavg;
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      bad = 0;
      repeat (hold) begin
        tick();
        if (!bus.out_valid || bus.out_avg != eavg || bus.in_ready) bad++;
      end
      check("backpressure", bad, 0);
      bus.out_ready = 1'b1;
    end
    tick();
    check("resume_in_ready", bus.in_ready, 1);
    check("resume_valid", bus.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f1, f2;
    logic signed [7:0] nc;
    Rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'sd0; bus.num_cfg = 8'sd0;
    bus.hlsm_done = 1'b0; bus.hlsm_avg = 8'sd0; bus.out_ready = 1'b1;
    exp_div0 = 1'b0; exp_tmo = 1'b0; last_avg = 8'sd0;
    #1;
    check("in_ready_por", bus.in_ready, 0);
    tick();
    tick();
    check_reset("por");
    Rst = 1'b0;
    #1;
    check("in_ready_after_por", bus.in_ready, 1);

    // 1..8 twice back-to-back: average 4 and the minimum batch period.
    for (int i = 0; i < 8; i++) bs[i] = 8'(i + 1);
    run_batch(8'sd8, 0, 1'b0, 1'b0, 1'b0, f1);
    run_batch(8'sd8, 0, 1'b0, 1'b0, 1'b0, f2);
    check("batch_period", f2 - f1, 22);

    for (int i = 0; i < 8; i++) bs[i] = 8'(-(i + 1));
    run_batch(8'sd8, 0, 1'b0, 1'b0, 1'b0, f1);

    for (int i = 0; i < 8; i++) bs[i] = 8'sd10;
    run_batch(8'sd0, 0, 1'b0, 1'b0, 1'b0, f1);
    for (int i = 0; i < 8; i++) bs[i] = 8'(i * 3);
    run_batch(8'sd4, 5, 1'b0, 1'b0, 1'b0, f1);

    for (int i = 0; i < 8; i++) bs[i] = 8'($urandom);
    run_batch(8'sd3, 0, 1'b0, 1'b1, 1'b0, f1);

    for (int i = 0; i < 8; i++) bs[i] = 8'($urandom);
    run_batch(8'sd5, 0, 1'b0, 1'b0, 1'b1, f1);
    for (int i = 0; i < 8; i++) bs[i] = 8'sd2;
    run_batch(8'sd2, 0, 1'b0, 1'b0, 1'b0, f1);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) bs[i] = 8'($urandom);
      nc = ($urandom_range(0, 5) == 0) ? 8'sd0 : 8'($urandom);
      run_batch(nc, int'($urandom_range(0, 3)), 1'b1, ($urandom_range(0, 7) == 0), 1'b0, f1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
